// File: rtl/lane_mult_ram.sv
// -----------------------------------------------------------------------------
// lane_mult_ram
//
// Multi-lane multiply-and-store buffer. Each accepted write beat carries LANES
// pairs of signed DATA_WIDTH operands. All pairs are multiplied in parallel
// through a two-stage pipeline (S0 capture, S1 multiply). The LANES products
// are then stored as one word in a single-port RAM (S2 write-back). The same
// port serves read-back by address. Write-back has priority over reads, so a
// read is refused (rd_ready low) in any cycle in which S1 holds a valid word.
//
// Optional feature (compile-time macro ACCUM_EN):
//   defined   - each lane keeps a 2*DATA_WIDTH wrapping accumulator. The
//               stored word is the updated accumulator. acc_clr restarts the
//               accumulation with the beat that carries it.
//   undefined - the stored word is the raw product and acc_clr is ignored.
//
// Ports:
//   clk, reset_n  rising-edge clock, asynchronous active-low reset
//   wr_valid      write beat present (always accepted)
//   wr_ready      constant 1; the pipeline never back-pressures
//   wr_addr       destination word address (wraps modulo depth)
//   wr_data       lane i: a = [(2i)*DW +: DW], b = [(2i+1)*DW +: DW]
//   acc_clr       accumulator clear, sampled with the write beat
//   rd_req        read request
//   rd_ready      high when the RAM port is free for a read this cycle
//   rd_addr       read word address
//   rd_valid      one-cycle pulse; rd_data carries the word just read
//   rd_data       lane i product at [i*2DW +: 2DW]; holds until the next read
//   busy          any pipeline stage valid
//   wr_count      words written to RAM, wraps modulo 2**(ADDR_WIDTH+1)
// -----------------------------------------------------------------------------
module lane_mult_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [2*LANES*DATA_WIDTH-1:0]   wr_data,
  input  logic                            acc_clr,
  input  logic                            rd_req,
  output logic                            rd_ready,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic                            rd_valid,
  output logic [LANES*2*DATA_WIDTH-1:0]   rd_data,
  output logic                            busy,
  output logic [ADDR_WIDTH:0]             wr_count
);

  localparam int PW    = 2 * DATA_WIDTH;   // product / accumulator width
  localparam int WW    = LANES * PW;       // stored word width
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Sign-extend an operand to the product width so the multiply is exact.
  function automatic logic signed [PW-1:0] sext(input logic [DATA_WIDTH-1:0] x);
    return {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
  endfunction

  // Pipeline control
  logic                          v0_q, v1_q;
  // S0 payload
  logic [2*LANES*DATA_WIDTH-1:0] opnd_q;
  logic [ADDR_WIDTH-1:0]         addr0_q;
  // S1 payload
  logic [WW-1:0]                 prod_d;
  logic [WW-1:0]                 word_d, word_q;
  logic [ADDR_WIDTH-1:0]         addr1_q;
  // Read side and bookkeeping
  logic                          rd_accept;
  logic                          rd_valid_q;
  logic [WW-1:0]                 rd_data_q;
  logic [ADDR_WIDTH:0]           wr_count_d, wr_count_q;
  // Storage
  logic [WW-1:0]                 ram_q [DEPTH];

  // ---------------------------------------------------------------------------
  // S1 multipliers: one signed multiply per lane, result truncated to 2*DW
  // (exact, since a DW x DW signed product always fits in 2*DW bits).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through the block can infer a latch.
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i*PW +: PW] = sext(opnd_q[(2*i)*DATA_WIDTH +: DATA_WIDTH])
                         * sext(opnd_q[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

`ifdef ACCUM_EN
  logic          clr0_q;
  logic [WW-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (wr_valid) clr0_q <= acc_clr;
  end

  // Clear and accumulate in one step: the beat carrying acc_clr becomes the
  // first term of the new sum rather than being added to the old total.
  always_comb begin
    word_d = '0;
    for (int i = 0; i < LANES; i++) begin
      word_d[i*PW +: PW] = (clr0_q ? '0 : acc_q[i*PW +: PW]) + prod_d[i*PW +: PW];
    end
  end

  // Accumulators advance only when a beat actually moves from S0 to S1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  acc_q <= '0;
    else if (v0_q) acc_q <= word_d;
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign word_d         = prod_d;
`endif

  // ---------------------------------------------------------------------------
  // Control state: valid bits, write counter and read register.
  // ---------------------------------------------------------------------------
  assign rd_accept  = rd_req & ~v1_q;
  assign wr_count_d = v1_q ? wr_count_q + CNT_ONE : wr_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      wr_count_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      v0_q       <= wr_valid;
      v1_q       <= v0_q;
      wr_count_q <= wr_count_d;
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= ram_q[rd_addr];
    end
  end

  // Datapath payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      opnd_q  <= wr_data;
      addr0_q <= wr_addr;
    end
    if (v0_q) begin
      word_q  <= word_d;
      addr1_q <= addr0_q;
    end
  end

  // S2 write-back. A read is never accepted in the same cycle (rd_ready = !v1),
  // so the array sees at most one access per cycle.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM and keeps its contents across reset.
    if (v1_q) ram_q[addr1_q] <= word_q;
  end

  assign wr_ready = 1'b1;
  assign rd_ready = ~v1_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = v0_q | v1_q;
  assign wr_count = wr_count_q;

endmodule
